// File: rtl/fifo_gray_pkg.sv
// Purpose : shared constants and Gray/binary helpers for the async FIFO pointer logic.
// Latency : combinational helpers only, no state.
// Backpres: n/a (no handshake in this package).
package fifo_gray_pkg;

    // Supported pointer geometry; pointers carry one extra wrap bit over the address.
    localparam int MIN_ADDR_WIDTH = 2;
    localparam int MAX_ADDR_WIDTH = 16;
    localparam int GRAY_MAX_W     = MAX_ADDR_WIDTH + 1;

    // Widest pointer any instance can use; narrower callers zero-extend in and
    // truncate out, which is exact for both conversions below.
    typedef logic [GRAY_MAX_W-1:0] gvec_t;

    // Pointer width for a given address width (address plus wrap bit).
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_ptr_gray_decoder.sv
// Purpose : Gray-to-binary conversion of a W-bit pointer (XOR prefix chain from the MSB).
// Latency : purely combinational.
// Backpres: none; output follows input continuously.
// Ports   : gray (in, W) Gray-coded pointer; bin (out, W) binary equivalent.
module gray_decoder #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin        = '0;
        bin[W-1]   = gray[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/fifo_gray_ptr.sv
// Purpose : one side of an async FIFO: binary/Gray pointer plus registered full or empty flag.
// Latency : pointer, gray_ptr, flag and level all update on the edge after an accepted inc.
// Backpres: inc is dropped while flag is set (full on write side, empty on read side).
// Ports   : CLK, RST (async active-low), inc, remote_gray (already synchronised)
//           -> addr, gray_ptr (registered, CDC-safe), flag, level.
// Option  : define FIFO_GRAY_PTR_LEVEL_EN to register occupancy on level; otherwise level is 0.
module fifo_gray_ptr
    import fifo_gray_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter bit WRITE_SIDE = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   remote_gray,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   gray_ptr,
    output logic                  flag,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    // Read side comes out of reset empty, write side not full.
    localparam logic FLAG_RST = ~WRITE_SIDE;

    if (ADDR_WIDTH < MIN_ADDR_WIDTH || ADDR_WIDTH > MAX_ADDR_WIDTH) begin : g_bad_width
        $error("fifo_gray_ptr: ADDR_WIDTH out of range");
    end

    logic [PTR_W-1:0] bin_q, bin_d;
    logic [PTR_W-1:0] gray_q, gray_d;
    logic             flag_q, flag_d;
    logic             accept;
    logic [PTR_W-1:0] remote_full;

    always_comb begin
        accept = inc & ~flag_q;
        bin_d  = bin_q + PTR_W'(accept);
        gray_d = PTR_W'(bin2gray(GRAY_MAX_W'(bin_d)));
        // Full means the writer is exactly one lap ahead: in Gray code that is
        // the reader's pointer with its top two bits inverted.
        remote_full = {~remote_gray[PTR_W-1:PTR_W-2], remote_gray[PTR_W-3:0]};
        // Evaluated every cycle (not only on accept) so the flag releases as soon
        // as the synchronised remote pointer moves.
        if (WRITE_SIDE) begin
            flag_d = (gray_d == remote_full);
        end else begin
            flag_d = (gray_d == remote_gray);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bin_q  <= '0;
            gray_q <= '0;
            flag_q <= FLAG_RST;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            flag_q <= flag_d;
        end
    end

    assign addr     = bin_q[ADDR_WIDTH-1:0];
    assign gray_ptr = gray_q;
    assign flag     = flag_q;

`ifdef FIFO_GRAY_PTR_LEVEL_EN
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] level_q, level_d;

    gray_decoder #(.W(PTR_W)) u_gray_decoder (
        .gray (remote_gray),
        .bin  (rbin)
    );

    // Modulo-2^PTR_W difference gives 0..2^ADDR_WIDTH occupancy directly.
    always_comb begin
        if (WRITE_SIDE) begin
            level_d = bin_d - rbin;
        end else begin
            level_d = rbin - bin_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = '0;
`endif

endmodule
